sdp_ram: RTL and testbench

Parametrised simple dual-port RAM with one write port and one read port on a single clock. It adds per-byte write enables, a configurable read pipeline depth with a valid flag, and a selectable read-during-write policy. Out-of-range addresses are handled safely. It is the common storage primitive under FIFOs, line buffers and coefficient tables, and is inferable as block or distributed RAM.

---
 rtl/sdp_ram.sv | 106 ++++++++++
 tb/tb_sdp_ram.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port with byte-lane enables, one read port with
// a 0..4 stage valid-tagged read pipeline and selectable same-address collision policy.
module sdp_ram #(
  parameter int unsigned MEM_WIDTH    = 16,
  parameter int unsigned MEM_DEPTH    = 66,
  parameter int unsigned BYTE_WIDTH   = 8,
  parameter int unsigned READ_LATENCY = 1,
  parameter string       RW_MODE      = "read_first",
  parameter string       MEM_TYPE     = "distributed",
  parameter string       MEM_FILE     = "",
  parameter int unsigned ADDR_WIDTH   = $clog2(MEM_DEPTH),
  localparam int unsigned NB          = (MEM_WIDTH + BYTE_WIDTH - 1) / BYTE_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [NB-1:0]         wr_be_i,
  input  logic [MEM_WIDTH-1:0]  wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [MEM_WIDTH-1:0]  rd_data_o,
  output logic                  rd_valid_o
);

  localparam bit WRITE_FIRST = (RW_MODE == "write_first");

  // Parameter sanity, caught at elaboration
  if (MEM_TYPE != "block" && MEM_TYPE != "distributed") begin : g_bad_mem_type
    $error("sdp_ram: MEM_TYPE must be block or distributed");
  end
  if (RW_MODE != "read_first" && RW_MODE != "write_first") begin : g_bad_rw_mode
    $error("sdp_ram: RW_MODE must be read_first or write_first");
  end
  if (READ_LATENCY > 4) begin : g_bad_latency
    $error("sdp_ram: READ_LATENCY must be in 0..4");
  end
  if (READ_LATENCY == 0 && MEM_TYPE == "block") begin : g_bad_block_l0
    $error("sdp_ram: block memory needs READ_LATENCY >= 1");
  end

  logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];

  // Power-up contents only; the array itself is never reset
  initial begin
    for (int unsigned i = 0; i < MEM_DEPTH; i++) mem[i] = '0;
  end

  logic [MEM_WIDTH-1:0] wr_mask;
  logic                 wr_hit;
  logic                 rd_hit;
  logic                 collide;
  logic [MEM_WIDTH-1:0] rd_old;
  logic [MEM_WIDTH-1:0] rd_word;

  // Expand lane enables to a bit mask; the top lane may be partial
  always_comb begin
    wr_mask = '0;
    for (int unsigned i = 0; i < MEM_WIDTH; i++) begin
      wr_mask[i] = wr_be_i[i / BYTE_WIDTH];
    end
  end

  assign wr_hit = wr_en_i && (32'(wr_addr_i) < MEM_DEPTH);
  assign rd_hit = 32'(rd_addr_i) < MEM_DEPTH;

  always_ff @(posedge clk_i) begin
    if (wr_hit) begin
      mem[wr_addr_i] <= (mem[wr_addr_i] & ~wr_mask) | (wr_data_i & wr_mask);
    end
  end

  // Word seen by the read port this cycle, including write_first bypass
  always_comb begin
    rd_old  = rd_hit ? mem[rd_addr_i] : '0;
    collide = WRITE_FIRST && wr_hit && rd_hit && (wr_addr_i == rd_addr_i);
    rd_word = collide ? ((rd_old & ~wr_mask) | (wr_data_i & wr_mask)) : rd_old;
  end

  if (READ_LATENCY == 0) begin : g_comb_read
    assign rd_data_o  = rd_word;
    assign rd_valid_o = rd_en_i & arstn_i;
  end else begin : g_pipe_read
    logic [MEM_WIDTH-1:0]    pipe_data [READ_LATENCY];
    logic [READ_LATENCY-1:0] pipe_vld;

    // Each data stage loads only behind a valid, so the output holds between reads
    always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
        pipe_vld <= '0;
        for (int unsigned s = 0; s < READ_LATENCY; s++) pipe_data[s] <= '0;
      end else begin
        pipe_vld[0] <= rd_en_i;
        if (rd_en_i) pipe_data[0] <= rd_word;
        for (int unsigned s = 1; s < READ_LATENCY; s++) begin
          pipe_vld[s] <= pipe_vld[s-1];
          if (pipe_vld[s-1]) pipe_data[s] <= pipe_data[s-1];
        end
      end
    end

    assign rd_data_o  = pipe_data[READ_LATENCY-1];
    assign rd_valid_o = pipe_vld[READ_LATENCY-1];
  end

endmodule

// File: tb/tb_sdp_ram.sv
// Scoreboard bench for sdp_ram: three instances (L=2 read_first, L=4 write_first,
// L=0 write_first) share stimulus and are checked against an array model.
module tb_sdp_ram;
  localparam int unsigned W  = 16;
  localparam int unsigned D  = 66;
  localparam int unsigned AW = 7;
  localparam int unsigned NB = 2;
  localparam int unsigned NI = 3;
  localparam int unsigned LAT [NI] = '{2, 4, 0};
  localparam bit          WF  [NI] = '{1'b0, 1'b1, 1'b1};

  typedef struct {
    int unsigned  cyc;
    logic [W-1:0] data;
  } exp_t;

  exp_t         sbq [NI][$];
  logic [W-1:0] ref_mem [D];
  int unsigned  tests = 0;
  int unsigned  fails = 0;
  int unsigned  cnt = 0;

  logic          clk = 1'b0;
  logic          arstn = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [NB-1:0] wr_be = '0;
  logic [W-1:0]  wr_data = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [W-1:0]  rd_data [NI];
  logic          rd_valid [NI];

  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 1;

  function automatic void chk(string name, int unsigned g, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, g, cnt, act, exp);
    end
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sdp_ram #(
      .MEM_WIDTH(W), .MEM_DEPTH(D), .BYTE_WIDTH(8), .READ_LATENCY(LAT[g]),
      .RW_MODE(WF[g] ? "write_first" : "read_first"),
      .MEM_TYPE(LAT[g] == 0 ? "distributed" : "block"), .MEM_FILE("")
    ) u_dut (
      .clk_i(clk), .arstn_i(arstn), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
      .wr_be_i(wr_be), .wr_data_i(wr_data), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
      .rd_data_o(rd_data[g]), .rd_valid_o(rd_valid[g])
    );

    logic [W-1:0] last = '0;
    exp_t         e;

    always @(negedge arstn) last = '0;

    // Monitor: pop and compare whenever the instance presents a valid read
    always @(negedge clk) begin
      if (!arstn) begin
        chk("reset_valid", g, 32'(rd_valid[g]), 32'(0));
        chk("reset_data", g, 32'(rd_data[g]), 32'(0));
      end else if (rd_valid[g]) begin
        if (sbq[g].size() == 0) begin
          chk("unexpected_valid", g, 32'(rd_valid[g]), 32'(0));
        end else begin
          e = sbq[g].pop_front();
          chk("latency", g, cnt, e.cyc);
          chk("rd_data", g, 32'(rd_data[g]), 32'(e.data));
        end
        last = rd_data[g];
      end else if (sbq[g].size() != 0 && sbq[g][0].cyc <= cnt) begin
        chk("missing_valid", g, 32'(rd_valid[g]), 32'(1));
        void'(sbq[g].pop_front());
      end
    end

    if (LAT[g] != 0) begin : g_hold
      always @(negedge clk) begin
        if (arstn && !rd_valid[g]) chk("hold_data", g, 32'(rd_data[g]), 32'(last));
      end
    end
  end

  // Drive one cycle; the model predicts the read result under both policies
  task automatic step(bit we, int unsigned wa, logic [NB-1:0] be, logic [W-1:0] wd,
                      bit re, int unsigned ra);
    logic [W-1:0] pre, post;
    wr_en = we; wr_addr = AW'(wa); wr_be = be; wr_data = wd;
    rd_en = re; rd_addr = AW'(ra);
    pre = (ra < D) ? ref_mem[ra] : '0;
    if (we && wa < D) begin
      for (int k = 0; k < NB; k++) begin
        if (be[k]) ref_mem[wa][k*8 +: 8] = wd[k*8 +: 8];
      end
    end
    post = (ra < D) ? ref_mem[ra] : '0;
    if (re && arstn) begin
      for (int i = 0; i < NI; i++) sbq[i].push_back(exp_t'{cnt + LAT[i], WF[i] ? post : pre});
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic idle(int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < D; i++) ref_mem[i] = '0;

    // Reset held three cycles, then a read of a never-written word
    repeat (3) @(posedge clk);
    #1 arstn = 1'b1;
    step(0, 0, '0, '0, 1, 5);
    idle(5);

    // Byte-lane merge
    step(1, 3, 2'b11, 16'hABCD, 0, 0);
    step(1, 3, 2'b10, 16'h1200, 0, 0);
    step(0, 0, '0, '0, 1, 3);
    idle(5);

    // Same-address collision, then a follow-up read
    step(1, 7, 2'b11, 16'h1111, 0, 0);
    step(1, 7, 2'b01, 16'h2222, 1, 7);
    step(0, 0, '0, '0, 1, 7);
    idle(5);

    // Streaming reads of addresses 0..9
    for (int unsigned a = 0; a < 10; a++) step(1, a, 2'b11, W'($urandom), 0, 0);
    for (int unsigned a = 0; a < 10; a++) step(0, 0, '0, '0, 1, a);
    idle(6);

    // Out-of-range write and reads
    step(1, 70, 2'b11, 16'hFFFF, 0, 0);
    step(0, 0, '0, '0, 1, 70);
    step(0, 0, '0, '0, 1, 6);
    idle(5);

    // Reads in flight are dropped by an asynchronous reset pulse
    step(1, 0, 2'b11, 16'h5A5A, 0, 0);
    step(1, 1, 2'b11, 16'hC3C3, 0, 0);
    step(0, 0, '0, '0, 1, 0);
    step(0, 0, '0, '0, 1, 1);
    #1 arstn = 1'b0;
    for (int i = 0; i < NI; i++) sbq[i].delete();
    #1 arstn = 1'b1;
    idle(6);
    step(0, 0, '0, '0, 1, 0);
    step(0, 0, '0, '0, 1, 1);
    idle(5);

    // Randomised traffic with biased same-address collisions and out-of-range addresses
    for (int unsigned n = 0; n < 600; n++) begin
      int unsigned wa, ra;
      wa = $urandom_range(0, 79);
      ra = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 79);
      step(bit'($urandom_range(0, 1)), wa, NB'($urandom), W'($urandom),
           bit'($urandom_range(0, 2) != 0), ra);
    end
    idle(8);

    for (int unsigned i = 0; i < NI; i++) chk("drained", i, sbq[i].size(), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
